// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: width, op encodings,
// divider state encoding and operand-status bit positions.
package muldiv_pkg;

  localparam int XLEN = 32;

  // Division op encoding: bit0 = 1 selects unsigned, bit1 = 1 selects remainder.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Bit positions inside ab_status {Bm1,B1,B0,Am1,A1,A0}.
  localparam int AB_A0  = 0;
  localparam int AB_A1  = 1;
  localparam int AB_AM1 = 2;
  localparam int AB_B0  = 3;
  localparam int AB_B1  = 4;
  localparam int AB_BM1 = 5;

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep the difference
// only when it did not borrow.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            unused_rem_msb;

  // The stored remainder is always below the divisor, so its MSB is zero
  // and drops out of the shift.
  assign unused_rem_msb = rem_i[XLEN];

  assign shifted = {rem_i[XLEN-1:0], bit_i};
  assign diff    = {1'b0, shifted} - {2'b00, divisor_i};
  assign q_bit_o = ~diff[XLEN+1];
  assign rem_o   = q_bit_o ? diff[XLEN:0] : shifted;

endmodule

// File: rtl/muldiv_div_iter.sv
// Iterative restoring divider: special operands finish in one cycle,
// everything else takes 32 CALC cycles plus a sign-fix cycle.
module muldiv_div_iter #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            sign_a_i,
  input  logic            sign_b_i,
  input  logic [XLEN-1:0] a_raw_i,
  input  logic [XLEN-1:0] a_neg_i,
  input  logic [5:0]      ab_status_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  import muldiv_pkg::*;

  localparam int CNT_W = $clog2(XLEN);

  state_e          state_q;
  op_e             op_q;
  logic            sign_a_q;
  logic            sign_b_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] quot_q;     // dividend bits shift out, quotient bits shift in
  logic [XLEN:0]   rem_q;      // partial remainder
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN:0]   step_rem;
  logic            step_q_bit;

  logic            spec_hit;
  logic [XLEN-1:0] spec_quot;
  logic [XLEN-1:0] spec_rem;

  logic [XLEN-1:0] fix_quot;
  logic [XLEN-1:0] fix_rem;
  logic            unused_ab;

  // A=1 and A=-1 have no shortcut in the divider; only the B flags and A0 matter.
  assign unused_ab = ab_status_i[AB_A1] ^ ab_status_i[AB_AM1];

  muldiv_div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .bit_i     (quot_q[XLEN-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  // Special-operand results resolved at start, priority B0 > A0 > B1 > Bm1.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    spec_hit  = 1'b0;
    spec_quot = '0;
    spec_rem  = '0;
    if (ab_status_i[AB_B0]) begin
      spec_hit  = 1'b1;
      spec_quot = '1;
      spec_rem  = a_raw_i;
    end else if (ab_status_i[AB_A0]) begin
      spec_hit  = 1'b1;
    end else if (ab_status_i[AB_B1]) begin
      spec_hit  = 1'b1;
      spec_quot = a_raw_i;
    end else if (ab_status_i[AB_BM1]) begin
      // a_neg wraps for the most negative dividend, giving the overflow result.
      spec_hit  = 1'b1;
      spec_quot = a_neg_i;
    end
  end

  // Sign correction of the magnitude quotient and remainder.
  always_comb begin
    fix_quot = quot_q;
    fix_rem  = rem_q[XLEN-1:0];
    if (op_is_signed(op_q) && (sign_a_q ^ sign_b_q)) fix_quot = -quot_q;
    if (op_is_signed(op_q) && sign_a_q)              fix_rem  = -rem_q[XLEN-1:0];
  end

  // Control FSM and datapath registers; kill overrides everything but reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_DIV;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      result_o  <= '0;
    end else if (kill_i) begin
      state_q <= ST_IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_q      <= op_e'(op_i);
            sign_a_q  <= sign_a_i;
            sign_b_q  <= sign_b_i;
            divisor_q <= divisor_i;
            busy_o    <= 1'b1;
            if (spec_hit) begin
              quot_q   <= spec_quot;
              rem_q    <= {1'b0, spec_rem};
              cnt_q    <= '0;
              result_o <= op_is_rem(op_e'(op_i)) ? spec_rem : spec_quot;
              done_o   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              quot_q  <= dividend_i;
              rem_q   <= '0;
              cnt_q   <= CNT_W'(XLEN - 1);
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          quot_q <= {quot_q[XLEN-2:0], step_q_bit};
          rem_q  <= step_rem;
          if (cnt_q == '0) begin
            state_q <= ST_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_FIX: begin
          result_o <= op_is_rem(op_q) ? fix_rem : fix_quot;
          done_o   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_div_iter.md
MULDIV_DIV_ITER -- requirements
Module: muldiv_div_iter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start_i, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port kill_i, input, 1 bit: synchronous abort from pipeline flush.
REQ-006 The block SHALL have port op_i, input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU; bit0=0 selects signed.
REQ-007 The block SHALL have ports dividend_i and divisor_i, input, 32 bits each: sign-magnitude-adjusted operands from the operand-preparation stage.
REQ-008 The block SHALL have ports sign_a_i and sign_b_i, input, 1 bit each: original rs1[31] and rs2[31].
REQ-009 The block SHALL have port a_raw_i, input, 32 bits: original rs1.
REQ-010 The block SHALL have port a_neg_i, input, 32 bits: two's complement of rs1.
REQ-011 The block SHALL have port ab_status_i, input, 6 bits: {Bm1,B1,B0,Am1,A1,A0}; Bm1 already gated to signed division.
REQ-012 The block SHALL have ports busy_o, output, 1 bit (not IDLE); done_o, output, 1 bit (result valid pulse); result_o, output, 32 bits.

Function
REQ-013 The block SHALL implement states IDLE, CALC, FIX, DONE; DONE returns to IDLE unconditionally.
REQ-014 The block SHALL, in IDLE with start_i=1 and kill_i=0, latch op, signs, a_raw_i, a_neg_i and operands.
REQ-015 The block SHALL resolve special cases at start in priority B0 > A0 > B1 > Bm1, go directly to DONE, and assert done_o in the cycle after start.
REQ-016 The block SHALL return, for B0, quotient 0xFFFFFFFF and remainder a_raw_i.
REQ-017 The block SHALL return, for A0, quotient 0 and remainder 0.
REQ-018 The block SHALL return, for B1, quotient a_raw_i and remainder 0.
REQ-019 The block SHALL return, for Bm1, quotient a_neg_i and remainder 0, so that 0x80000000/-1 yields 0x80000000.
REQ-020 The block SHALL otherwise enter CALC and perform 32 restoring iterations, one quotient bit per cycle, MSB first, with a 33-bit partial remainder and a 5-bit down-counter from 31.
REQ-021 The block SHALL leave CALC for FIX on the edge where the counter is 0.
REQ-022 The block SHALL, in FIX, negate the quotient if signed and sign_a^sign_b, negate the remainder if signed and sign_a, select quotient (op_i[1]=0) or remainder, then enter DONE.
REQ-023 The block SHALL deliver the normal-path result with done_o high exactly 34 cycles after the start cycle.
REQ-024 The block SHALL hold done_o high for one cycle in DONE only.
REQ-025 The block SHALL hold result_o from DONE until the next result is written.
REQ-026 The block SHALL ignore start_i when not in IDLE.
REQ-027 The block SHALL, on kill_i=1 in any state, enter IDLE on the next edge without asserting done_o; kill_i wins over a simultaneous start_i.
REQ-028 The block SHALL keep busy_o=0 in IDLE and busy_o=1 in CALC, FIX and DONE.

Reset
REQ-029 The block SHALL, while reset_i=0, asynchronously force state IDLE, counter 0, busy_o=0, done_o=0, result_o=0 and all datapath registers 0.
REQ-030 The block SHALL, after reset deasserts mid-operation, wait for a fresh start_i; no partial result is produced.

Structure
REQ-031 The following SHALL live in shared package muldiv_pkg: op encodings, state encoding, AB_status bit indices, and XLEN.
REQ-032 The block SHALL contain one combinational sub-module, muldiv_div_step, computing one restoring iteration (shifted remainder, trial subtract, quotient bit).

Verification
REQ-033 The bench SHALL check DIV 100/7 -> 14 and REM 100/7 -> 2, each with done_o at cycle 34.
REQ-034 The bench SHALL check DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF.
REQ-035 The bench SHALL check DIVU 0x1234/0 -> 0xFFFFFFFF and REMU 0x1234/0 -> 0x1234, each with done_o one cycle after start.
REQ-036 The bench SHALL check DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same operands -> 0, each in one cycle.
REQ-037 The bench SHALL check DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF and REMU 0xFFFFFFFF/2 -> 1.
REQ-038 The bench SHALL check that kill_i at CALC cycle 10 gives busy_o=0 next cycle and no done_o, and that the following DIV 9/3 -> 3 is correct.
